// File: rtl/mesh_cfg_loader.sv
// Programming-phase transmitter for the Accelerant mesh: streams per-PE config beats onto the broadcast buses.
// Optional macro CFG_CLEAR_EN inserts a one-cycle PE clear (pe_reset) between start and loading.
module mesh_cfg_loader #(
    parameter int NUM_PE        = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_instr,
    input  logic [31:0]       cfg_data,
    output logic [NUM_PE-1:0] pe_load,
    output logic [3:0]        pe_instruction,
    output logic [31:0]       pe_data,
    output logic              pe_reset,
    output logic              busy,
    output logic              done,
    output logic              mesh_run,
    output logic              err_illegal
);

    localparam int IDX_W = $clog2(NUM_PE);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SETTLE, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] settle_cnt;
    logic             accept;
    logic             legal;

    assign accept = cfg_valid && cfg_ready;

    always_comb begin
        legal = 1'b0;
        case (cfg_instr)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
    end

    // Strobes (pe_load, done, pe_reset) default low each cycle; abort overrides every non-idle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            cfg_ready      <= 1'b0;
            pe_load        <= '0;
            pe_instruction <= '0;
            pe_data        <= '0;
            pe_reset       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mesh_run       <= 1'b0;
            err_illegal    <= 1'b0;
        end else begin
            pe_load  <= '0;
            done     <= 1'b0;
            pe_reset <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                cfg_ready <= 1'b0;
                busy      <= 1'b0;
                mesh_run  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            idx         <= '0;
                            err_illegal <= 1'b0;
                            mesh_run    <= 1'b0;
                            busy        <= 1'b1;
`ifdef CFG_CLEAR_EN
                            state       <= CLEAR;
                            pe_reset    <= 1'b1;
`else
                            state       <= LOAD;
                            cfg_ready   <= 1'b1;
`endif
                        end
                    end
                    CLEAR: begin
                        state     <= LOAD;
                        cfg_ready <= 1'b1;
                    end
                    LOAD: begin
                        if (accept) begin
                            // Illegal beats consume a PE slot but never strobe it or touch the buses.
                            if (legal) begin
                                pe_load        <= NUM_PE'(1) << idx;
                                pe_instruction <= cfg_instr;
                                pe_data        <= cfg_data;
                            end else begin
                                err_illegal <= 1'b1;
                            end
                            if (idx == IDX_W'(NUM_PE - 1)) begin
                                state      <= SETTLE;
                                cfg_ready  <= 1'b0;
                                settle_cnt <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == CNT_W'(SETTLE_CYCLES)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            mesh_run <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mesh_cfg_loader.sv
// Directed self-checking bench for mesh_cfg_loader (NUM_PE=4, SETTLE_CYCLES=2).
// Handles both builds: with CFG_CLEAR_EN the loader spends one extra CLEAR cycle after start.
module tb_mesh_cfg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_instr;
    logic [31:0] cfg_data;
    logic [3:0]  pe_load;
    logic [3:0]  pe_instruction;
    logic [31:0] pe_data;
    logic        pe_reset;
    logic        busy;
    logic        done;
    logic        mesh_run;
    logic        err_illegal;

    int errors = 0;
    int checks = 0;

    logic [3:0]  b_instr [4];
    logic [31:0] b_data  [4];

    mesh_cfg_loader #(.NUM_PE(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_instr(cfg_instr), .cfg_data(cfg_data),
        .pe_load(pe_load), .pe_instruction(pe_instruction), .pe_data(pe_data), .pe_reset(pe_reset),
        .busy(busy), .done(done), .mesh_run(mesh_run), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef CFG_CLEAR_EN
        step();
`endif
    endtask

    task automatic go_idle();
        abort = 1'b1;
        step();
        abort     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if ({cfg_ready, pe_load, pe_reset, busy, done, mesh_run, err_illegal} !== 10'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0", {cfg_ready, pe_load, pe_reset, busy, done, mesh_run, err_illegal}); end
        checks++; if (pe_instruction !== 4'h0 || pe_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h/%h want 0/0", pe_instruction, pe_data); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: busy=%b ready=%b want 0 0", busy, cfg_ready); end
    endtask

    task automatic test_basic();
        do_start();
        checks++; if (cfg_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: ready=%b busy=%b want 1 1", cfg_ready, busy); end
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_instr = b_instr[i]; cfg_data = b_data[i];
            step();
            checks++; if (pe_load !== (4'b0001 << i)) begin errors++; $display("[TB] FAIL basic_load%0d: got %b want %b", i, pe_load, 4'b0001 << i); end
            checks++; if (pe_instruction !== b_instr[i] || pe_data !== b_data[i]) begin errors++; $display("[TB] FAIL basic_bus%0d: got %h/%h want %h/%h", i, pe_instruction, pe_data, b_instr[i], b_data[i]); end
        end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop: got %b want 0", cfg_ready); end
        cfg_valid = 1'b0;
        step();
        checks++; if (pe_load !== 4'b0 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_settle1: load=%b done=%b busy=%b want 0 0 1", pe_load, done, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_settle2: done=%b want 0", done); end
        step();
        checks++; if (done !== 1'b1 || mesh_run !== 1'b1 || busy !== 1'b0 || err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL basic_done: done=%b run=%b busy=%b err=%b want 1 1 0 0", done, mesh_run, busy, err_illegal); end
        step();
        checks++; if (done !== 1'b0 || mesh_run !== 1'b1) begin errors++; $display("[TB] FAIL basic_after: done=%b run=%b want 0 1", done, mesh_run); end
    endtask

    task automatic test_toggle();
        do_start();
        checks++; if (mesh_run !== 1'b0) begin errors++; $display("[TB] FAIL toggle_run_clear: got %b want 0", mesh_run); end
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_instr = b_instr[i]; cfg_data = b_data[i];
            step();
            cfg_valid = 1'b0;
            checks++; if (pe_load !== (4'b0001 << i) || pe_data !== b_data[i]) begin errors++; $display("[TB] FAIL toggle_load%0d: got %b/%h want %b/%h", i, pe_load, pe_data, 4'b0001 << i, b_data[i]); end
            if (i < 3) begin
                step();
                checks++; if (pe_load !== 4'b0 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL toggle_gap%0d: load=%b ready=%b want 0000 1", i, pe_load, cfg_ready); end
                checks++; if (pe_instruction !== b_instr[i]) begin errors++; $display("[TB] FAIL toggle_hold%0d: got %h want %h", i, pe_instruction, b_instr[i]); end
            end
        end
        step(); step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL toggle_early_done: got %b want 0", done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL toggle_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_illegal();
        logic [3:0] exp_load [4];
        exp_load[0] = 4'b0001; exp_load[1] = 4'b0010; exp_load[2] = 4'b0000; exp_load[3] = 4'b1000;
        do_start();
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_instr = (i == 2) ? 4'b0111 : b_instr[i]; cfg_data = b_data[i];
            step();
            checks++; if (pe_load !== exp_load[i]) begin errors++; $display("[TB] FAIL illegal_load%0d: got %b want %b", i, pe_load, exp_load[i]); end
            if (i == 2) begin
                checks++; if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_set: got %b want 1", err_illegal); end
                checks++; if (pe_instruction !== 4'h1 || pe_data !== 32'h40000000) begin errors++; $display("[TB] FAIL illegal_bus_hold: got %h/%h want 1/40000000", pe_instruction, pe_data); end
            end
        end
        cfg_valid = 1'b0;
        step(); step(); step();
        checks++; if (done !== 1'b1 || mesh_run !== 1'b1 || err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_done: done=%b run=%b err=%b want 1 1 1", done, mesh_run, err_illegal); end
        step();
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sticky: got %b want 1", err_illegal); end
        do_start();
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_clear_on_start: got %b want 0", err_illegal); end
        go_idle();
    endtask

    task automatic test_abort();
        int stray;
        do_start();
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1; cfg_instr = b_instr[i]; cfg_data = b_data[i];
            step();
        end
        cfg_instr = b_instr[2]; cfg_data = b_data[2];
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (pe_load !== 4'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 || mesh_run !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: load=%b ready=%b busy=%b run=%b done=%b want 0", pe_load, cfg_ready, busy, mesh_run, done); end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (pe_load !== 4'b0 || done !== 1'b0 || cfg_ready !== 1'b0) stray++;
        end
        cfg_valid = 1'b0;
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", stray); end
        do_start();
        cfg_valid = 1'b1; cfg_instr = b_instr[0]; cfg_data = b_data[0];
        step();
        checks++; if (pe_load !== 4'b0001 || pe_data !== b_data[0]) begin errors++; $display("[TB] FAIL abort_restart: got %b/%h want 0001/%h", pe_load, pe_data, b_data[0]); end
        go_idle();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b0 || pe_reset !== 1'b0) begin errors++; $display("[TB] FAIL abort_beats_start: busy=%b ready=%b clr=%b want 0 0 0", busy, cfg_ready, pe_reset); end
    endtask

    task automatic test_start_in_settle();
        int done_count;
        do_start();
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_instr = b_instr[i]; cfg_data = b_data[i];
            step();
        end
        cfg_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL settle_start_done: got %b want 1", done); end
        done_count = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) done_count++;
        end
        checks++; if (done_count !== 0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL settle_start_ignored: extra_done=%0d busy=%b ready=%b want 0 0 0", done_count, busy, cfg_ready); end
        checks++; if (mesh_run !== 1'b1) begin errors++; $display("[TB] FAIL settle_run_level: got %b want 1", mesh_run); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (mesh_run !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rerun_clear: run=%b busy=%b want 0 1", mesh_run, busy); end
        go_idle();
    endtask

    task automatic test_clear();
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef CFG_CLEAR_EN
        checks++; if (pe_reset !== 1'b1 || cfg_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_pulse: clr=%b ready=%b busy=%b want 1 0 1", pe_reset, cfg_ready, busy); end
        step();
        checks++; if (pe_reset !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_end: clr=%b ready=%b want 0 1", pe_reset, cfg_ready); end
`else
        checks++; if (pe_reset !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL noclear: clr=%b ready=%b want 0 1", pe_reset, cfg_ready); end
        step();
        checks++; if (pe_reset !== 1'b0) begin errors++; $display("[TB] FAIL noclear_hold: got %b want 0", pe_reset); end
`endif
        go_idle();
    endtask

    task automatic test_reset_mid_pass();
        do_start();
        cfg_valid = 1'b1; cfg_instr = b_instr[1]; cfg_data = b_data[1];
        step();
        reset = 1'b1;
        step();
        checks++; if (pe_load !== 4'b0 || busy !== 1'b0 || cfg_ready !== 1'b0 || pe_data !== 32'h0 || pe_instruction !== 4'h0) begin errors++; $display("[TB] FAIL reset_mid: load=%b busy=%b ready=%b bus=%h/%h want 0", pe_load, busy, cfg_ready, pe_instruction, pe_data); end
        reset = 1'b0; cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        b_instr[0] = 4'b0000; b_data[0] = 32'h3F800000;
        b_instr[1] = 4'b0001; b_data[1] = 32'h40000000;
        b_instr[2] = 4'b1010; b_data[2] = 32'h40400000;
        b_instr[3] = 4'b0011; b_data[3] = 32'h00000000;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_valid = 1'b0; cfg_instr = 4'h0; cfg_data = 32'h0;
        test_reset();
        test_basic();
        test_toggle();
        test_illegal();
        test_abort();
        test_start_in_settle();
        test_clear();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
